// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: owns the PC, fetches words over a req/ack
// memory handshake and hands them to the decoder over valid/ready.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        resetl,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic        uncond_branch,
    input  logic        branch,
    input  logic        zero,
    input  logic [63:0] br_pc,
    input  logic [63:0] br_imm,
    output logic [63:0] pc
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state;
    logic [63:0] pend;
    logic        taken;
    logic [63:0] target;
    logic        unused_bits;

    assign taken       = redirect_valid & (uncond_branch | (branch & zero));
    assign target      = {br_pc[63:2], 2'b00} + {br_imm[61:0], 2'b00};
    assign imem_addr   = pc;
    assign unused_bits = ^{br_pc[1:0], br_imm[63:62]};

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state       <= IDLE;
            pc          <= {RESET_PC[63:2], 2'b00};
            pend        <= '0;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (taken) begin
                            // Data for the wrong path is dropped; a new request starts at the target.
                            pc <= target;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            imem_req    <= 1'b0;
                            state       <= HOLD;
                        end
                    end else if (taken) begin
                        // Request must stay stable until acked, so park the target.
                        pend  <= target;
                        state <= DROP;
                    end
                end
                HOLD: begin
                    if (taken) begin
                        pc          <= target;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end else if (instr_ready) begin
                        pc          <= pc + 64'd4;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        pc    <= taken ? target : pend;
                        state <= FETCH;
                    end else if (taken) begin
                        pend <= target;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a latency-configurable memory and a
// transaction-level model of the expected fetch stream checked every cycle.
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h100;

    logic        CLK;
    logic        resetl;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic        uncond_branch;
    logic        branch;
    logic        zero;
    logic [63:0] br_pc;
    logic [63:0] br_imm;
    logic [63:0] pc;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_wait = 0;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .CLK(CLK), .resetl(resetl),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .uncond_branch(uncond_branch), .branch(branch), .zero(zero),
        .br_pc(br_pc), .br_imm(br_imm), .pc(pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return a[31:0] ^ 32'hD503_201F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Instruction memory: acks after mem_wait idle request cycles, forgets everything on reset.
    initial begin
        int cnt;
        cnt        = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge CLK or negedge resetl);
            if (!resetl) begin
                imem_ack = 1'b0;
                cnt      = 0;
            end else begin
                #2;
                if (!resetl || !imem_req) begin
                    imem_ack = 1'b0;
                    cnt      = 0;
                end else begin
                    if (imem_ack) cnt = 0;
                    if (cnt >= mem_wait) begin
                        imem_ack   = 1'b1;
                        imem_rdata = memf(imem_addr);
                    end else begin
                        imem_ack = 1'b0;
                        cnt++;
                    end
                end
            end
        end
    end

    // Model: where the next useful fetch must come from, and whether a delivery is due.
    logic [63:0] m_exp_fetch;
    logic        m_stale, m_deliver;
    logic        p_req, p_ack, p_valid, p_hs, p_taken;
    logic [63:0] p_addr, p_instr_pc;
    logic [31:0] p_instr;

    initial begin
        logic        tk;
        logic [63:0] tgt;
        m_exp_fetch = RST_PC;
        m_stale = 0; m_deliver = 0;
        p_req = 0; p_ack = 0; p_valid = 0; p_hs = 0; p_taken = 0;
        p_addr = 0; p_instr_pc = 0; p_instr = 0;
        forever begin
            @(negedge CLK);
            if (!resetl) begin
                chk("m_rst_req", imem_req, 0);
                chk("m_rst_valid", instr_valid, 0);
                chk("m_rst_instr", instr, 0);
                chk("m_rst_instr_pc", instr_pc, 0);
                chk("m_rst_pc", pc, RST_PC);
                m_exp_fetch = RST_PC;
                m_stale = 0; m_deliver = 0;
                p_req = 0; p_ack = 0; p_valid = 0; p_hs = 0; p_taken = 0;
            end else begin
                chk("m_addr_is_pc", imem_addr, pc);
                chk("m_pc_align", pc[1:0], 0);
                if (p_req && !p_ack) begin
                    chk("m_req_held", imem_req, 1);
                    chk("m_addr_held", imem_addr, p_addr);
                end
                if (imem_req && (!p_req || p_ack))
                    chk("m_new_req_addr", imem_addr, m_exp_fetch);
                if (p_valid && !p_hs && !p_taken) begin
                    chk("m_valid_held", instr_valid, 1);
                    chk("m_instr_held", instr, p_instr);
                    chk("m_instr_pc_held", instr_pc, p_instr_pc);
                end
                if (p_valid && (p_hs || p_taken))
                    chk("m_valid_drop", instr_valid, 0);
                if (!p_valid)
                    chk("m_delivery", instr_valid, m_deliver);
                if (instr_valid && !p_valid) begin
                    chk("m_deliv_pc", instr_pc, m_exp_fetch);
                    chk("m_deliv_instr", instr, memf(m_exp_fetch));
                end
                if (instr_valid)
                    chk("m_hold_pc", pc, instr_pc);

                tk  = redirect_valid & (uncond_branch | (branch & zero));
                tgt = (br_pc & ~64'd3) + br_imm * 64'd4;
                m_deliver = imem_req && imem_ack && !m_stale && !tk;
                if (tk)                              m_exp_fetch = tgt;
                else if (instr_valid && instr_ready) m_exp_fetch = m_exp_fetch + 64'd4;
                if (imem_req && imem_ack) m_stale = 0;
                else if (imem_req && tk)  m_stale = 1;
                p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
                p_valid = instr_valid; p_hs = instr_valid && instr_ready; p_taken = tk;
                p_instr = instr; p_instr_pc = instr_pc;
            end
        end
    end

    task automatic redir(input logic [63:0] bpc, input logic [63:0] imm);
        redirect_valid = 1; uncond_branch = 1; branch = 0; zero = 0;
        br_pc = bpc; br_imm = imm;
    endtask

    task automatic no_redir();
        redirect_valid = 0; uncond_branch = 0; branch = 0; zero = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        resetl = 0; instr_ready = 1; br_pc = 0; br_imm = 0;
        no_redir();
        repeat (3) step();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 64'h100);
        resetl = 1;
        chk("idle_req", imem_req, 0);

        // Sequential fetch, zero-wait memory
        step(); chk("f0_req", imem_req, 1); chk("f0_addr", imem_addr, 64'h100);
        step(); chk("d0_valid", instr_valid, 1); chk("d0_pc", instr_pc, 64'h100);
        chk("d0_instr", instr, 32'hD503211F); chk("d0_req", imem_req, 0);
        step(); chk("f1_addr", imem_addr, 64'h104); chk("f1_valid", instr_valid, 0);
        step(); chk("d1_pc", instr_pc, 64'h104); chk("d1_instr", instr, 32'hD503211B);
        step(); chk("f2_addr", imem_addr, 64'h108);

        // Decoder backpressure
        instr_ready = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", instr_valid, 1); chk("bp_instr_pc", instr_pc, 64'h108);
            chk("bp_req", imem_req, 0); chk("bp_pc", pc, 64'h108);
            if (i < 4) step();
        end
        instr_ready = 1;
        step(); chk("bp_release_pc", pc, 64'h10C); chk("bp_release_valid", instr_valid, 0);

        // Unconditional branch with negative offset, then untaken CBZ
        step(); chk("b_hold_pc", instr_pc, 64'h10C);
        redir(64'h200, 64'hFFFF_FFFF_FFFF_FFFE);
        step(); no_redir(); chk("b_target", imem_addr, 64'h1F8);
        step(); chk("cbz_hold_pc", instr_pc, 64'h1F8);
        redirect_valid = 1; branch = 1; zero = 0; br_pc = 64'h1F8; br_imm = 64'h10;
        step(); no_redir(); chk("cbz_not_taken", imem_addr, 64'h1FC);

        // Redirect during a 3-cycle memory wait
        mem_wait = 3;
        redir(64'h400, 64'h0);
        step(); no_redir();
        for (int i = 0; i < 3; i++) begin
            chk("drop_addr", imem_addr, 64'h1FC); chk("drop_valid", instr_valid, 0);
            step();
        end
        chk("drop_target", imem_addr, 64'h400); chk("drop_req", imem_req, 1);

        // Two redirects while waiting: latest wins
        redir(64'h480, 64'h0);
        step(); br_pc = 64'h500; chk("drop2_addr_a", imem_addr, 64'h400);
        step(); no_redir(); chk("drop2_addr_b", imem_addr, 64'h400);
        step(); chk("drop2_addr_c", imem_addr, 64'h400);
        step(); chk("drop2_target", imem_addr, 64'h500);

        // Redirect and ack in the same FETCH cycle
        mem_wait = 0;
        redir(64'h600, 64'h4);
        step(); no_redir(); chk("ra_target", imem_addr, 64'h610); chk("ra_valid", instr_valid, 0);
        step(); chk("ra_deliv_pc", instr_pc, 64'h610); chk("ra_deliv_instr", instr, 32'hD503260F);

        // Redirect and instr_ready in the same HOLD cycle
        redir(64'h700, 64'h1);
        step(); no_redir(); chk("rr_target", imem_addr, 64'h704); chk("rr_valid", instr_valid, 0);

        // PC wrap
        step(); chk("w_hold_pc", instr_pc, 64'h704);
        redir(64'hFFFF_FFFF_FFFF_FFF0, 64'h3);
        step(); no_redir(); chk("w_target", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(); chk("w_hold", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        mem_wait = 3;
        step(); chk("w_wrap_pc", pc, 64'h0); chk("w_wrap_req", imem_req, 1);

        // Async reset while a dropped request is outstanding
        redir(64'h800, 64'h0);
        step(); no_redir(); chk("ar_drop_addr", imem_addr, 64'h0);
        #2 resetl = 0;
        #1;
        chk("ar_req", imem_req, 0); chk("ar_valid", instr_valid, 0);
        chk("ar_pc", pc, 64'h100); chk("ar_instr", instr, 0); chk("ar_instr_pc", instr_pc, 0);
        step(); step();
        resetl = 1;
        chk("ar_idle_req", imem_req, 0);
        step(); chk("ar_restart_req", imem_req, 1); chk("ar_restart_addr", imem_addr, 64'h100);
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (instr_valid) seen = 1;
        end
        chk("ar_deliv_seen", seen, 1);
        chk("ar_deliv_pc", instr_pc, 64'h100);
        chk("ar_deliv_instr", instr, 32'hD503211F);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
